// File: rtl/axi_rr_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter.
// Write (AW/W/B) and read (AR/R) paths are arbitrated independently, each
// round-robin with a single outstanding transaction. WLAST towards the slave
// is regenerated from the latched AWLEN; wlast_err flags masters that disagree.
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   s0_axi_* / s1_axi_*   master-facing AXI4 ports (masters 0 and 1)
//   m_axi_*               slave-facing AXI4 port
//   wr_grant / rd_grant   one-hot owner of the write / read path, 0 when idle
//   wlast_err             high on a W handshake whose master WLAST is wrong
module axi_rr_arbiter_2to1 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 3,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  // master 0
  input  logic [ID_W-1:0]   s0_axi_awid,
  input  logic [ADDR_W-1:0] s0_axi_awaddr,
  input  logic [7:0]        s0_axi_awlen,
  input  logic [2:0]        s0_axi_awsize,
  input  logic [1:0]        s0_axi_awburst,
  input  logic              s0_axi_awvalid,
  output logic              s0_axi_awready,
  input  logic [DATA_W-1:0] s0_axi_wdata,
  input  logic [STRB_W-1:0] s0_axi_wstrb,
  input  logic              s0_axi_wlast,
  input  logic              s0_axi_wvalid,
  output logic              s0_axi_wready,
  output logic [ID_W-1:0]   s0_axi_bid,
  output logic [1:0]        s0_axi_bresp,
  output logic              s0_axi_bvalid,
  input  logic              s0_axi_bready,
  input  logic [ID_W-1:0]   s0_axi_arid,
  input  logic [ADDR_W-1:0] s0_axi_araddr,
  input  logic [7:0]        s0_axi_arlen,
  input  logic [2:0]        s0_axi_arsize,
  input  logic [1:0]        s0_axi_arburst,
  input  logic              s0_axi_arvalid,
  output logic              s0_axi_arready,
  output logic [ID_W-1:0]   s0_axi_rid,
  output logic [DATA_W-1:0] s0_axi_rdata,
  output logic [1:0]        s0_axi_rresp,
  output logic              s0_axi_rlast,
  output logic              s0_axi_rvalid,
  input  logic              s0_axi_rready,
  // master 1
  input  logic [ID_W-1:0]   s1_axi_awid,
  input  logic [ADDR_W-1:0] s1_axi_awaddr,
  input  logic [7:0]        s1_axi_awlen,
  input  logic [2:0]        s1_axi_awsize,
  input  logic [1:0]        s1_axi_awburst,
  input  logic              s1_axi_awvalid,
  output logic              s1_axi_awready,
  input  logic [DATA_W-1:0] s1_axi_wdata,
  input  logic [STRB_W-1:0] s1_axi_wstrb,
  input  logic              s1_axi_wlast,
  input  logic              s1_axi_wvalid,
  output logic              s1_axi_wready,
  output logic [ID_W-1:0]   s1_axi_bid,
  output logic [1:0]        s1_axi_bresp,
  output logic              s1_axi_bvalid,
  input  logic              s1_axi_bready,
  input  logic [ID_W-1:0]   s1_axi_arid,
  input  logic [ADDR_W-1:0] s1_axi_araddr,
  input  logic [7:0]        s1_axi_arlen,
  input  logic [2:0]        s1_axi_arsize,
  input  logic [1:0]        s1_axi_arburst,
  input  logic              s1_axi_arvalid,
  output logic              s1_axi_arready,
  output logic [ID_W-1:0]   s1_axi_rid,
  output logic [DATA_W-1:0] s1_axi_rdata,
  output logic [1:0]        s1_axi_rresp,
  output logic              s1_axi_rlast,
  output logic              s1_axi_rvalid,
  input  logic              s1_axi_rready,
  // slave side
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  // status
  output logic [1:0]        wr_grant,
  output logic [1:0]        rd_grant,
  output logic              wlast_err
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t    wstate;
  rstate_t    rstate;
  logic       wsel, wprio, rsel, rprio;
  logic [7:0] wlen, wcnt;

  // Phase decodes: which master currently owns which channel
  logic w_addr0, w_addr1, w_data0, w_data1, w_resp0, w_resp1;
  logic r_addr0, r_addr1, r_data0, r_data1;

  assign w_addr0 = (wstate == W_ADDR) && !wsel;
  assign w_addr1 = (wstate == W_ADDR) &&  wsel;
  assign w_data0 = (wstate == W_DATA) && !wsel;
  assign w_data1 = (wstate == W_DATA) &&  wsel;
  assign w_resp0 = (wstate == W_RESP) && !wsel;
  assign w_resp1 = (wstate == W_RESP) &&  wsel;
  assign r_addr0 = (rstate == R_ADDR) && !rsel;
  assign r_addr1 = (rstate == R_ADDR) &&  rsel;
  assign r_data0 = (rstate == R_DATA) && !rsel;
  assign r_data1 = (rstate == R_DATA) &&  rsel;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs_last;
  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;
  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign r_hs_last = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  // Round-robin pick: priority holder wins a tie, otherwise the lone requester
  logic w_pick, r_pick;
  assign w_pick = (s0_axi_awvalid && s1_axi_awvalid) ? wprio : s1_axi_awvalid;
  assign r_pick = (s0_axi_arvalid && s1_axi_arvalid) ? rprio : s1_axi_arvalid;

  // Write path state machine
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate <= W_IDLE;
      wsel   <= 1'b0;
      wprio  <= 1'b0;
      wlen   <= 8'd0;
      wcnt   <= 8'd0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (s0_axi_awvalid || s1_axi_awvalid) begin
            wsel   <= w_pick;
            wstate <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (aw_hs) begin
            wlen   <= m_axi_awlen;
            wcnt   <= 8'd0;
            wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // wcnt may roll over to 0 after beat 256; the compare already used it
            wcnt <= wcnt + 8'd1;
            if (wcnt == wlen) wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            wprio  <= ~wsel;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read path state machine
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate <= R_IDLE;
      rsel   <= 1'b0;
      rprio  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s0_axi_arvalid || s1_axi_arvalid) begin
            rsel   <= r_pick;
            rstate <= R_ADDR;
          end
        end
        R_ADDR: if (ar_hs) rstate <= R_DATA;
        R_DATA: begin
          if (r_hs_last) begin
            rprio  <= ~rsel;
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign wr_grant = (wstate == W_IDLE) ? 2'b00 : (wsel ? 2'b10 : 2'b01);
  assign rd_grant = (rstate == R_IDLE) ? 2'b00 : (rsel ? 2'b10 : 2'b01);

  // AW channel
  assign m_axi_awid    = w_addr1 ? s1_axi_awid    : (w_addr0 ? s0_axi_awid    : '0);
  assign m_axi_awaddr  = w_addr1 ? s1_axi_awaddr  : (w_addr0 ? s0_axi_awaddr  : '0);
  assign m_axi_awlen   = w_addr1 ? s1_axi_awlen   : (w_addr0 ? s0_axi_awlen   : '0);
  assign m_axi_awsize  = w_addr1 ? s1_axi_awsize  : (w_addr0 ? s0_axi_awsize  : '0);
  assign m_axi_awburst = w_addr1 ? s1_axi_awburst : (w_addr0 ? s0_axi_awburst : '0);
  assign m_axi_awvalid = (w_addr1 & s1_axi_awvalid) | (w_addr0 & s0_axi_awvalid);
  assign s0_axi_awready = w_addr0 & m_axi_awready;
  assign s1_axi_awready = w_addr1 & m_axi_awready;

  // W channel; WLAST comes from the beat count, not from the master
  logic w_mst_last;
  assign w_mst_last   = wsel ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wdata  = w_data1 ? s1_axi_wdata : (w_data0 ? s0_axi_wdata : '0);
  assign m_axi_wstrb  = w_data1 ? s1_axi_wstrb : (w_data0 ? s0_axi_wstrb : '0);
  assign m_axi_wvalid = (w_data1 & s1_axi_wvalid) | (w_data0 & s0_axi_wvalid);
  assign m_axi_wlast  = (wstate == W_DATA) && (wcnt == wlen);
  assign s0_axi_wready = w_data0 & m_axi_wready;
  assign s1_axi_wready = w_data1 & m_axi_wready;
  assign wlast_err     = w_hs & (w_mst_last != m_axi_wlast);

  // B channel
  assign s0_axi_bid    = w_resp0 ? m_axi_bid   : '0;
  assign s0_axi_bresp  = w_resp0 ? m_axi_bresp : '0;
  assign s0_axi_bvalid = w_resp0 & m_axi_bvalid;
  assign s1_axi_bid    = w_resp1 ? m_axi_bid   : '0;
  assign s1_axi_bresp  = w_resp1 ? m_axi_bresp : '0;
  assign s1_axi_bvalid = w_resp1 & m_axi_bvalid;
  assign m_axi_bready  = (w_resp0 & s0_axi_bready) | (w_resp1 & s1_axi_bready);

  // AR channel
  assign m_axi_arid    = r_addr1 ? s1_axi_arid    : (r_addr0 ? s0_axi_arid    : '0);
  assign m_axi_araddr  = r_addr1 ? s1_axi_araddr  : (r_addr0 ? s0_axi_araddr  : '0);
  assign m_axi_arlen   = r_addr1 ? s1_axi_arlen   : (r_addr0 ? s0_axi_arlen   : '0);
  assign m_axi_arsize  = r_addr1 ? s1_axi_arsize  : (r_addr0 ? s0_axi_arsize  : '0);
  assign m_axi_arburst = r_addr1 ? s1_axi_arburst : (r_addr0 ? s0_axi_arburst : '0);
  assign m_axi_arvalid = (r_addr1 & s1_axi_arvalid) | (r_addr0 & s0_axi_arvalid);
  assign s0_axi_arready = r_addr0 & m_axi_arready;
  assign s1_axi_arready = r_addr1 & m_axi_arready;

  // R channel
  assign s0_axi_rid    = r_data0 ? m_axi_rid   : '0;
  assign s0_axi_rdata  = r_data0 ? m_axi_rdata : '0;
  assign s0_axi_rresp  = r_data0 ? m_axi_rresp : '0;
  assign s0_axi_rlast  = r_data0 & m_axi_rlast;
  assign s0_axi_rvalid = r_data0 & m_axi_rvalid;
  assign s1_axi_rid    = r_data1 ? m_axi_rid   : '0;
  assign s1_axi_rdata  = r_data1 ? m_axi_rdata : '0;
  assign s1_axi_rresp  = r_data1 ? m_axi_rresp : '0;
  assign s1_axi_rlast  = r_data1 & m_axi_rlast;
  assign s1_axi_rvalid = r_data1 & m_axi_rvalid;
  assign m_axi_rready  = (r_data0 & s0_axi_rready) | (r_data1 & s1_axi_rready);

endmodule

// File: tb/tb_axi_rr_arbiter_2to1.sv
// Directed self-checking bench for axi_rr_arbiter_2to1 with a small
// always-ready AXI slave responder.
module tb_axi_rr_arbiter_2to1;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // master-side signals, index = master number
  logic [2:0]  awid [2];
  logic [31:0] awaddr [2];
  logic [7:0]  awlen [2];
  logic [2:0]  awsize [2];
  logic [1:0]  awburst [2];
  logic        awvalid [2], awready [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        wlast [2], wvalid [2], wready [2];
  logic [2:0]  bid [2];
  logic [1:0]  bresp [2];
  logic        bvalid [2], bready [2];
  logic [2:0]  arid [2];
  logic [31:0] araddr [2];
  logic [7:0]  arlen [2];
  logic [2:0]  arsize [2];
  logic [1:0]  arburst [2];
  logic        arvalid [2], arready [2];
  logic [2:0]  rid [2];
  logic [31:0] rdata [2];
  logic [1:0]  rresp [2];
  logic        rlast [2], rvalid [2], rready [2];

  // slave-side signals
  logic [2:0]  m_awid, m_arid, m_bid, m_rid;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rlast, m_rvalid, m_rready;
  logic [1:0]  wr_grant, rd_grant;
  logic        wlast_err;

  axi_rr_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .ID_W(3)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_awid(awid[0]), .s0_axi_awaddr(awaddr[0]), .s0_axi_awlen(awlen[0]),
    .s0_axi_awsize(awsize[0]), .s0_axi_awburst(awburst[0]), .s0_axi_awvalid(awvalid[0]),
    .s0_axi_awready(awready[0]), .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(wstrb[0]),
    .s0_axi_wlast(wlast[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
    .s0_axi_bid(bid[0]), .s0_axi_bresp(bresp[0]), .s0_axi_bvalid(bvalid[0]),
    .s0_axi_bready(bready[0]), .s0_axi_arid(arid[0]), .s0_axi_araddr(araddr[0]),
    .s0_axi_arlen(arlen[0]), .s0_axi_arsize(arsize[0]), .s0_axi_arburst(arburst[0]),
    .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]), .s0_axi_rid(rid[0]),
    .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rlast(rlast[0]),
    .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]),
    .s1_axi_awid(awid[1]), .s1_axi_awaddr(awaddr[1]), .s1_axi_awlen(awlen[1]),
    .s1_axi_awsize(awsize[1]), .s1_axi_awburst(awburst[1]), .s1_axi_awvalid(awvalid[1]),
    .s1_axi_awready(awready[1]), .s1_axi_wdata(wdata[1]), .s1_axi_wstrb(wstrb[1]),
    .s1_axi_wlast(wlast[1]), .s1_axi_wvalid(wvalid[1]), .s1_axi_wready(wready[1]),
    .s1_axi_bid(bid[1]), .s1_axi_bresp(bresp[1]), .s1_axi_bvalid(bvalid[1]),
    .s1_axi_bready(bready[1]), .s1_axi_arid(arid[1]), .s1_axi_araddr(araddr[1]),
    .s1_axi_arlen(arlen[1]), .s1_axi_arsize(arsize[1]), .s1_axi_arburst(arburst[1]),
    .s1_axi_arvalid(arvalid[1]), .s1_axi_arready(arready[1]), .s1_axi_rid(rid[1]),
    .s1_axi_rdata(rdata[1]), .s1_axi_rresp(rresp[1]), .s1_axi_rlast(rlast[1]),
    .s1_axi_rvalid(rvalid[1]), .s1_axi_rready(rready[1]),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
    .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
    .m_axi_bready(m_bready), .m_axi_arid(m_arid), .m_axi_araddr(m_araddr),
    .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_rid(m_rid),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .wlast_err(wlast_err)
  );

  // Slave responder: always ready on AW/W/AR; B one cycle after the last W beat;
  // read data beat b of a burst at address A is A + b.
  logic        sl_bvalid, sl_rbusy;
  logic [2:0]  sl_bid, sl_rid;
  logic [31:0] sl_raddr;
  logic [7:0]  sl_rlen, sl_rbeat;

  assign m_awready = 1'b1;
  assign m_wready  = 1'b1;
  assign m_arready = 1'b1;
  assign m_bvalid  = sl_bvalid;
  assign m_bid     = sl_bid;
  assign m_bresp   = 2'b00;
  assign m_rvalid  = sl_rbusy;
  assign m_rid     = sl_rid;
  assign m_rdata   = sl_raddr + 32'(sl_rbeat);
  assign m_rresp   = 2'b00;
  assign m_rlast   = sl_rbusy && (sl_rbeat == sl_rlen);

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sl_bvalid <= 1'b0;
      sl_bid    <= 3'd0;
    end else begin
      if (m_awvalid && m_awready) sl_bid <= m_awid;
      if (m_wvalid && m_wready && m_wlast) sl_bvalid <= 1'b1;
      else if (sl_bvalid && m_bready) sl_bvalid <= 1'b0;
    end
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sl_rbusy <= 1'b0;
      sl_rid   <= 3'd0;
      sl_raddr <= 32'd0;
      sl_rlen  <= 8'd0;
      sl_rbeat <= 8'd0;
    end else if (m_arvalid && m_arready && !sl_rbusy) begin
      sl_rbusy <= 1'b1;
      sl_rid   <= m_arid;
      sl_raddr <= m_araddr;
      sl_rlen  <= m_arlen;
      sl_rbeat <= 8'd0;
    end else if (sl_rbusy && m_rready) begin
      if (sl_rbeat == sl_rlen) sl_rbusy <= 1'b0;
      else sl_rbeat <= sl_rbeat + 8'd1;
    end
  end

  int errors = 0;
  int checks = 0;
  int aw_order [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full write burst from master m; bad_beat >= 0 makes the master raise wlast on that beat only
  task automatic do_write(input int m, input int len, input logic [31:0] addr,
                          input logic [31:0] dbase, input int bad_beat);
    bit   got;
    logic drv_last, exp_last;
    awid[m] = 3'(m + 1); awaddr[m] = addr; awlen[m] = 8'(len);
    awsize[m] = 3'd2; awburst[m] = 2'd1; awvalid[m] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 600 && !got; n++) begin
      #1;
      if (awready[m]) begin
        got = 1'b1;
        aw_order.push_back(m);
        check($sformatf("aw_addr_m%0d", m), 64'(m_awaddr), 64'(addr));
        check("aw_len", 64'(m_awlen), 64'(len));
        check("aw_size", 64'(m_awsize), 64'd2);
        check("wr_grant_busy", 64'(wr_grant), (m == 0) ? 64'd1 : 64'd2);
      end
      tick();
    end
    check("aw_handshake_seen", 64'(got), 64'd1);
    awvalid[m] = 1'b0;
    if (!got) return;
    for (int b = 0; b <= len; b++) begin
      wdata[m] = dbase + 32'(b);
      wstrb[m] = 4'hF;
      drv_last = (bad_beat >= 0) ? (b == bad_beat) : (b == len);
      exp_last = (b == len);
      wlast[m] = drv_last;
      wvalid[m] = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        #1;
        if (wready[m]) begin
          got = 1'b1;
          check($sformatf("w_data_b%0d", b), 64'(m_wdata), 64'(dbase + 32'(b)));
          check($sformatf("m_wlast_b%0d", b), 64'(m_wlast), 64'(exp_last));
          check($sformatf("wlast_err_b%0d", b), 64'(wlast_err), 64'(drv_last != exp_last));
          check("w_strb", 64'(m_wstrb), 64'hF);
        end
        tick();
      end
      if (!got) begin
        check($sformatf("w_handshake_b%0d", b), 64'(got), 64'd1);
        wvalid[m] = 1'b0;
        return;
      end
    end
    wvalid[m] = 1'b0;
    wlast[m] = 1'b0;
    bready[m] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (bvalid[m]) begin
        got = 1'b1;
        check("b_id", 64'(bid[m]), 64'(m + 1));
        check("b_resp", 64'(bresp[m]), 64'd0);
        check("b_other_quiet", 64'(bvalid[1 - m]), 64'd0);
      end
      tick();
    end
    check("b_handshake_seen", 64'(got), 64'd1);
    bready[m] = 1'b0;
    #1;
    check("wr_grant_idle_after_b", 64'(wr_grant), 64'd0);
  endtask

  // Consume len+1 read beats on master m, checking data/last/routing
  task automatic read_beats(input int m, input int len, input logic [31:0] addr);
    bit got;
    rready[m] = 1'b1;
    for (int b = 0; b <= len; b++) begin
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        #1;
        if (rvalid[m]) begin
          got = 1'b1;
          check($sformatf("r_data_m%0d_b%0d", m, b), 64'(rdata[m]), 64'(addr + 32'(b)));
          check($sformatf("r_last_b%0d", b), 64'(rlast[m]), 64'(b == len));
          check("r_id", 64'(rid[m]), 64'(m + 1));
          check("r_resp", 64'(rresp[m]), 64'd0);
          check("r_other_quiet", 64'(rvalid[1 - m]), 64'd0);
        end
        tick();
      end
      if (!got) begin
        check($sformatf("r_handshake_b%0d", b), 64'(got), 64'd1);
        rready[m] = 1'b0;
        return;
      end
    end
    rready[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input int len, input logic [31:0] addr);
    bit got;
    arid[m] = 3'(m + 1); araddr[m] = addr; arlen[m] = 8'(len);
    arsize[m] = 3'd2; arburst[m] = 2'd1; arvalid[m] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 600 && !got; n++) begin
      #1;
      if (arready[m]) begin
        got = 1'b1;
        check("ar_addr", 64'(m_araddr), 64'(addr));
        check("ar_burst", 64'(m_arburst), 64'd1);
        check("ar_size", 64'(m_arsize), 64'd2);
        check("rd_grant_busy", 64'(rd_grant), (m == 0) ? 64'd1 : 64'd2);
      end
      tick();
    end
    check("ar_handshake_seen", 64'(got), 64'd1);
    arvalid[m] = 1'b0;
    if (got) read_beats(m, len, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      awid[i] = '0; awaddr[i] = '0; awlen[i] = '0; awsize[i] = '0; awburst[i] = '0;
      awvalid[i] = 1'b0; wdata[i] = '0; wstrb[i] = '0; wlast[i] = 1'b0; wvalid[i] = 1'b0;
      bready[i] = 1'b0; arid[i] = '0; araddr[i] = '0; arlen[i] = '0; arsize[i] = '0;
      arburst[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
    end
    aresetn = 1'b0;
    #1;
    // reset state
    check("rst_wr_grant", 64'(wr_grant), 64'd0);
    check("rst_rd_grant", 64'(rd_grant), 64'd0);
    check("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_m_bready", 64'(m_bready), 64'd0);
    check("rst_wlast_err", 64'(wlast_err), 64'd0);
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // simultaneous writes: master 0 first, then 1; twice
    fork
      do_write(0, 1, 32'h100, 32'h10, -1);
      do_write(1, 1, 32'h180, 32'h20, -1);
    join
    fork
      do_write(0, 1, 32'h200, 32'h30, -1);
      do_write(1, 1, 32'h280, 32'h40, -1);
    join
    check("order_size", 64'(aw_order.size()), 64'd4);
    if (aw_order.size() == 4) begin
      check("order_0", 64'(aw_order[0]), 64'd0);
      check("order_1", 64'(aw_order[1]), 64'd1);
      check("order_2", 64'(aw_order[2]), 64'd0);
      check("order_3", 64'(aw_order[3]), 64'd1);
    end

    // single write from master 0
    do_write(0, 3, 32'h10, 32'hA0, -1);

    // concurrent write by master 1 and read by master 0
    fork
      do_write(1, 7, 32'h400, 32'hB0, -1);
      do_read(0, 3, 32'h500);
    join

    // master raises wlast on beat 2 of a 4-beat burst
    do_write(0, 3, 32'h600, 32'hC0, 1);

    // maximum burst
    do_write(1, 255, 32'h1000, 32'h0, -1);

    // reset in the middle of a read by master 0
    arid[0] = 3'd1; araddr[0] = 32'h700; arlen[0] = 8'd3;
    arsize[0] = 3'd2; arburst[0] = 2'd1; arvalid[0] = 1'b1;
    tick();
    tick();
    arvalid[0] = 1'b0;
    rready[0] = 1'b1;
    tick();
    #1;
    check("mid_rd_beat2_valid", 64'(rvalid[0]), 64'd1);
    check("mid_rd_beat2_data", 64'(rdata[0]), 64'h701);
    aresetn = 1'b0;
    #1;
    check("arst_rd_grant", 64'(rd_grant), 64'd0);
    check("arst_wr_grant", 64'(wr_grant), 64'd0);
    check("arst_s0_rvalid", 64'(rvalid[0]), 64'd0);
    check("arst_m_rready", 64'(m_rready), 64'd0);
    check("arst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("arst_s0_arready", 64'(arready[0]), 64'd0);
    rready[0] = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    arid[1] = 3'd2; araddr[1] = 32'h800; arlen[1] = 8'd1;
    arsize[1] = 3'd2; arburst[1] = 2'd1; arvalid[1] = 1'b1;
    tick();
    #1;
    check("post_rst_rd_grant", 64'(rd_grant), 64'd2);
    check("post_rst_m_arvalid", 64'(m_arvalid), 64'd1);
    check("post_rst_m_araddr", 64'(m_araddr), 64'h800);
    tick();
    arvalid[1] = 1'b0;
    read_beats(1, 1, 32'h800);
    #1;
    check("final_rd_grant", 64'(rd_grant), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter_2to1.md
# axi_rr_arbiter_2to1

Two-master to one-slave AXI4 arbiter that lets a pair of AXI masters share the single `axi4_slave` instance. It sits between the masters and the slave, with the protocol checker on its slave-side (`m_axi_*`) port. Write (AW/W/B) and read (AR/R) paths are arbitrated independently, each with round-robin priority and one outstanding transaction. It also regenerates WLAST from the latched AWLEN and flags masters whose WLAST disagrees.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `STRB_W = DATA_W/8`
- `ID_W`, 3, ID width, passed through unchanged

Ports (`N` is 0 or 1; `s0_`/`s1_` are master-facing and take the ports of masters 0 and 1; `m_` faces the slave):
- `aclk`  in  1  single clock; all logic rises on its edge
- `aresetn`  in  1  reset, asynchronous and active-low
- `sN_axi_awid/awaddr/awlen/awsize/awburst/awvalid`  in  ID_W/ADDR_W/8/3/2/1  write address from master N
- `sN_axi_awready`  out  1
- `sN_axi_wdata/wstrb/wlast/wvalid`  in  DATA_W/STRB_W/1/1  write data from master N
- `sN_axi_wready`  out  1
- `sN_axi_bid/bresp/bvalid`  out  ID_W/2/1  write response to master N
- `sN_axi_bready`  in  1
- `sN_axi_arid/araddr/arlen/arsize/arburst/arvalid`  in  ID_W/ADDR_W/8/3/2/1  read address from master N
- `sN_axi_arready`  out  1
- `sN_axi_rid/rdata/rresp/rlast/rvalid`  out  ID_W/DATA_W/2/1/1  read data to master N
- `sN_axi_rready`  in  1
- `m_axi_*`  mirror of one `sN_axi_*` set with directions reversed
  - The slave's lock, cache, prot, qos and user inputs are tied to 0 at integration.
- `wr_grant`  out  2  one-hot: write path owner; 0 when idle
- `rd_grant`  out  2  one-hot: read path owner; 0 when idle
- `wlast_err`  out  1  one-cycle pulse on a W beat whose `sN_axi_wlast` ≠ the generated WLAST

## Operation
Write FSM, states W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE:
- **W_IDLE:** if any `sN_axi_awvalid`, register `wsel`. If both are valid, pick the master named by `wprio`; otherwise pick the valid one. Then go to W_ADDR.
- **W_ADDR:** the AW payload and `awvalid` of the `wsel` master are muxed onto `m_axi_*`. `s[wsel]_awready = m_axi_awready`. On handshake, latch `awlen` into `wlen`, clear 8-bit `wcnt`, go to W_DATA.
- **W_DATA:** W is muxed from `wsel`, and `m_axi_wlast = (wcnt == wlen)`. Each W handshake increments `wcnt`; the handshake where `wcnt == wlen` moves to W_RESP.
  - `wlast_err` pulses on any W handshake where the master's `wlast` ≠ `(wcnt == wlen)`.
  - The burst still completes on the count, not on the master's `wlast`.
- **W_RESP:** B is routed only to `wsel` (`s[wsel]_bvalid = m_axi_bvalid`, `m_axi_bready = s[wsel]_bready`). On handshake go to W_IDLE and set `wprio = ~wsel`.

Read FSM, states R_IDLE → R_ADDR → R_DATA → R_IDLE:
- Arbitration is identical, using `rsel` and `rprio`.
- **R_DATA:** R is routed to `rsel`. The R handshake with `m_axi_rlast = 1` returns to R_IDLE and sets `rprio = ~rsel`.

General rules:
- Signals of the non-granted master: ready and valid outputs are 0, and payload outputs (`bid`, `bresp`, `rdata`, …) are 0.
- `m_axi` payloads are 0 in states that do not own the channel; `m_axi` valids and readys are 0 outside their owning state.
- Write and read paths are fully independent. The same master may hold both, or the two masters may hold one each, concurrently.
- A master's W beats issued before its AW is granted simply stall (`wready = 0`).

## Timing
- Reset values:
  - all FSMs IDLE; `wprio = rprio = 0`; `wcnt = wlen = 0`
  - every valid and ready output 0; `wr_grant = rd_grant = 0`; `wlast_err = 0`
- Assertion of `aresetn` mid-transaction forces IDLE immediately; outputs drop asynchronously with no completion.
- Arbitration latency is one cycle: `awvalid` high in cycle T while IDLE → `m_axi_awvalid` high in cycle T+1.
- Path muxes are combinational (zero added latency per beat). `wr_grant`/`rd_grant` equal the one-hot of `wsel`/`rsel` in non-IDLE states.
- After the final B or R handshake there is one IDLE cycle before the next grant. Back-to-back throughput is at most one transaction per (beats + 3) cycles on the write path and per (beats + 2) cycles on the read path.
- If a request arrives on the same cycle the other master's transaction completes, the new master wins by priority in the following IDLE cycle.
- `wlen = 255` runs 256 beats; `wcnt` must not wrap before the compare.

## Test plan
- **Single write from master 0:** `awaddr = 0x10`, `awlen = 3`, data 0xA0..0xA3 → slave gets 4 beats, `m_axi_wlast` on beat 4 only, `s0_bvalid` with OKAY, `wr_grant` is 01 and then 00.
- **Simultaneous writes after reset:** both masters present AW → master 0 served first, then master 1. After that, both request again → master 0 again (priority alternates per completion).
- **Concurrent paths:** write by master 1 (`awlen = 7`) overlapped with a read by master 0 (`arlen = 3`) → both complete independently, and `s1` never sees `rvalid`.
- **WLAST mismatch:** master asserts `wlast` on beat 2 of an `awlen = 3` burst → `wlast_err` pulses on beat 2, and `m_axi_wlast` asserts on beat 4 only.
- **Reset mid-burst:** deassert `aresetn` during beat 2 of a read → all valids and readys 0 and grants 00 immediately; after release, a new read from master 1 is granted within 1 cycle of `arvalid`.
- **Maximum burst:** `awlen = 255` → 256 beats, single WLAST, correct B routing.
